// File: rtl/uart_rx_fifo.sv
// Receive-side character FIFO between the UART RX controller and the bus.
// Stores {parity_err, data} per entry, registered pop, threshold irq, sticky overflow.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = $clog2(FIFO_DEPTH),
  parameter int CNT_W      = ADDR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  parity_ok,
  input  logic                  rd_en,
  input  logic                  flush,
  input  logic                  ovf_clr,
  input  logic [CNT_W-1:0]      thresh,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  parity_err_out,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow,
  output logic                  irq_thresh
);

  typedef logic [DATA_WIDTH:0] entry_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  entry_t            mem [FIFO_DEPTH];
  entry_t            rd_word;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  count_nxt;
  logic              push_ok;
  logic              pop_ok;
  logic              ovf_evt;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);

  // a pop frees a slot, so a push into a full fifo still lands
  assign pop_ok  = rd_en && !empty;
  assign push_ok = wr_en && (!full || pop_ok);
  assign ovf_evt = wr_en && full && !pop_ok;

  assign rd_word = mem[rd_ptr];

  assign irq_thresh = (thresh != '0) && (count >= thresh);

  always_comb begin
    count_nxt = count;
    unique case (1'b1)
      push_ok && !pop_ok: count_nxt = count + 1'b1;
      pop_ok && !push_ok: count_nxt = count - 1'b1;
      default:            count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush)
      mem[wr_ptr] <= {~parity_ok, data_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      data_out       <= '0;
      parity_err_out <= 1'b0;
      rd_valid       <= 1'b0;
      overflow       <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      rd_valid <= pop_ok;
      count    <= count_nxt;
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        rd_ptr         <= rd_ptr + 1'b1;
        data_out       <= rd_word[DATA_WIDTH-1:0];
        parity_err_out <= rd_word[DATA_WIDTH];
      end
      if (ovf_evt)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed pushes/pops,
// expected pops queued by stimulus, checked by a rd_valid monitor.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       wr_en, parity_ok, rd_en, flush, ovf_clr;
  logic [4:0] thresh;
  logic [7:0] data_out;
  logic       parity_err_out, rd_valid, empty, full, overflow, irq_thresh;
  logic [4:0] count;

  int checks = 0;
  int passed = 0;
  logic [8:0] exp_q [$];

  always #5 clk = ~clk;

  uart_rx_fifo dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en),
    .parity_ok(parity_ok), .rd_en(rd_en), .flush(flush),
    .ovf_clr(ovf_clr), .thresh(thresh), .data_out(data_out),
    .parity_err_out(parity_err_out), .rd_valid(rd_valid),
    .empty(empty), .full(full), .count(count),
    .overflow(overflow), .irq_thresh(irq_thresh)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_pop: got %0h, want none",
                 {parity_err_out, data_out});
      end else begin
        chk("pop_data", {23'b0, parity_err_out, data_out}, {23'b0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    wr_en = 0; rd_en = 0; flush = 0; ovf_clr = 0; parity_ok = 1;
  endtask

  task automatic push(input logic [7:0] d, input logic pok);
    data_in = d; parity_ok = pok; wr_en = 1;
    tick();
  endtask

  task automatic pop(input logic [8:0] e);
    exp_q.push_back(e);
    rd_en = 1;
    tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    rst_n = 0; data_in = 0; wr_en = 0; parity_ok = 1;
    rd_en = 0; flush = 0; ovf_clr = 0; thresh = 0;
    #12;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_irq", irq_thresh, 0);
    @(posedge clk); #1;
    rst_n = 1;

    // 1: single char
    push(8'hA5, 1);
    chk("t1_count1", count, 1);
    pop({1'b0, 8'hA5});
    chk("t1_valid", rd_valid, 1);
    chk("t1_count0", count, 0);
    chk("t1_empty", empty, 1);
    drain();

    // 2: fill, overflow, drain in order
    for (int i = 0; i < 16; i++) push(8'(i), 1);
    chk("t2_full", full, 1);
    chk("t2_count", count, 16);
    chk("t2_ovf0", overflow, 0);
    push(8'hFF, 1);
    chk("t2_ovf1", overflow, 1);
    chk("t2_count_hold", count, 16);
    // set wins over clear
    data_in = 8'hEE; wr_en = 1; ovf_clr = 1;
    tick();
    chk("t2_ovf_setwins", overflow, 1);
    ovf_clr = 1;
    tick();
    chk("t2_ovf_clr", overflow, 0);
    for (int i = 0; i < 16; i++) pop({1'b0, 8'(i)});
    chk("t2_empty", empty, 1);
    drain();

    // 3: push+pop while full
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i), 1);
    exp_q.push_back({1'b0, 8'h10});
    data_in = 8'h55; wr_en = 1; rd_en = 1;
    tick();
    chk("t3_count", count, 16);
    chk("t3_ovf", overflow, 0);
    for (int i = 1; i < 16; i++) pop({1'b0, 8'(8'h10 + i)});
    pop({1'b0, 8'h55});
    chk("t3_empty", empty, 1);
    drain();

    // 4: push+pop on empty, no bypass
    data_in = 8'h3C; wr_en = 1; rd_en = 1;
    tick();
    chk("t4_valid0", rd_valid, 0);
    chk("t4_count", count, 1);
    chk("t4_dout_hold", data_out, 8'h55);
    pop({1'b0, 8'h3C});
    drain();

    // 5: threshold irq and parity error
    thresh = 4;
    for (int i = 0; i < 3; i++) push(8'(8'h20 + i), 1);
    chk("t5_irq0", irq_thresh, 0);
    push(8'h23, 1);
    chk("t5_irq1", irq_thresh, 1);
    pop({1'b0, 8'h20});
    chk("t5_irq_drop", irq_thresh, 0);
    pop({1'b0, 8'h21});
    pop({1'b0, 8'h22});
    pop({1'b0, 8'h23});
    push(8'h81, 0);
    pop({1'b1, 8'h81});
    drain();
    thresh = 17;
    for (int i = 0; i < 16; i++) push(8'(i), 1);
    chk("t5_thresh_big", irq_thresh, 0);
    flush = 1;
    tick();

    // 6: flush then async reset mid-push
    thresh = 1;
    ovf_clr = 1;
    tick();
    for (int i = 0; i < 5; i++) push(8'(8'h40 + i), 1);
    push(8'hFF, 1);
    push(8'hFF, 1);
    for (int i = 0; i < 11; i++) push(8'hFF, 1);
    push(8'hFF, 1);
    chk("t6_ovf_pre", overflow, 1);
    flush = 1; wr_en = 1; rd_en = 1;
    tick();
    chk("t6_fl_count", count, 0);
    chk("t6_fl_empty", empty, 1);
    chk("t6_fl_ovf", overflow, 0);
    chk("t6_fl_valid", rd_valid, 0);
    chk("t6_fl_dout", data_out, 8'h81);
    rd_en = 1;
    tick();
    chk("t6_empty_rd", rd_valid, 0);
    push(8'h66, 1);
    push(8'h67, 1);
    chk("t6_irq_pre", irq_thresh, 1);
    data_in = 8'h68; wr_en = 1;
    #2 rst_n = 0;
    #1;
    chk("t6_rst_count", count, 0);
    chk("t6_rst_empty", empty, 1);
    chk("t6_rst_dout", data_out, 0);
    chk("t6_rst_irq", irq_thresh, 0);
    wr_en = 0;
    @(posedge clk); #1;
    rst_n = 1;
    rd_en = 1;
    tick();
    chk("t6_lost", rd_valid, 0);
    chk("t6_post_count", count, 0);
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1);
  end

endmodule
